// File: rtl/color_encoder.sv
// Streaming RGB444 -> palette index quantizer: nearest-centroid search over
// palette entries 1..8, one entry per clock, with an optional transparent key.
module color_encoder #(
  parameter logic [11:0] TRANSPARENT_KEY = 12'h000,
  parameter bit          KEY_EN          = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] in_rgb,
  input  logic        in_is_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_index,
  output logic [9:0]  out_dist,
  output logic [1:0]  dbg_state
);

  // Handshake: a transfer happens on a rising clk edge where valid && ready;
  // valid never depends on ready, and payload is held while valid && !ready.

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [3:0]  idx;
  logic [3:0]  best_idx;
  logic [9:0]  best_dist;
  logic [11:0] rgb_q;
  logic        is_b_q;
  logic [9:0]  cur_dist;
  logic        better;

  function automatic logic [11:0] pal_rgb(input logic [3:0] i, input logic b);
    logic [11:0] c;
    case (i)
      4'd1:    c = b ? 12'h8DF : 12'hD42;
      4'd2:    c = b ? 12'h009 : 12'h921;
      4'd3:    c = 12'hFF9;
      4'd4:    c = 12'h210;
      4'd5:    c = 12'h778;
      4'd6:    c = 12'h6B4;
      4'd7:    c = 12'hDD0;
      default: c = 12'hFFF;
    endcase
    return c;
  endfunction

  function automatic logic [7:0] chan_sq(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] d;
    d = (a > b) ? (a - b) : (b - a);
    return {4'd0, d} * {4'd0, d};
  endfunction

  function automatic logic [9:0] sq_dist(input logic [11:0] a, input logic [11:0] b);
    return {2'd0, chan_sq(a[11:8], b[11:8])}
         + {2'd0, chan_sq(a[7:4],  b[7:4])}
         + {2'd0, chan_sq(a[3:0],  b[3:0])};
  endfunction

  assign cur_dist  = sq_dist(rgb_q, pal_rgb(idx, is_b_q));
  // Strict compare: on a tie the earlier (lower) index is kept.
  assign better    = (cur_dist < best_dist);
  assign in_ready  = rst_n && (state == IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_index <= 4'd0;
      out_dist  <= 10'd0;
      idx       <= 4'd1;
      best_idx  <= 4'd1;
      best_dist <= 10'h3FF;
      rgb_q     <= 12'h000;
      is_b_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            rgb_q  <= in_rgb;
            is_b_q <= in_is_b;
            if (KEY_EN && (in_rgb == TRANSPARENT_KEY)) begin
              state     <= DONE;
              out_valid <= 1'b1;
              out_index <= 4'd0;
              out_dist  <= 10'd0;
            end else begin
              state     <= SCAN;
              idx       <= 4'd1;
              best_idx  <= 4'd1;
              best_dist <= 10'h3FF;
            end
          end
        end
        SCAN: begin
          if (better) begin
            best_idx  <= idx;
            best_dist <= cur_dist;
          end
          if (idx == 4'd8) begin
            // Fold the final compare straight into the result registers.
            state     <= DONE;
            out_valid <= 1'b1;
            out_index <= better ? idx : best_idx;
            out_dist  <= better ? cur_dist : best_dist;
          end else begin
            idx <= idx + 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_color_encoder.sv
// Directed bench for color_encoder: hand-computed palette searches, key path,
// backpressure and mid-scan reset, checked with immediate assertions.
module tb_color_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_is_b;
  logic [11:0] in_rgb;
  logic        out_valid, out_ready;
  logic [3:0]  out_index;
  logic [9:0]  out_dist;
  logic [1:0]  dbg_state;

  logic        nk_in_valid, nk_in_ready, nk_in_is_b;
  logic [11:0] nk_in_rgb;
  logic        nk_out_valid, nk_out_ready;
  logic [3:0]  nk_out_index;
  logic [9:0]  nk_out_dist;
  logic [1:0]  nk_dbg_state;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  color_encoder u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_rgb(in_rgb), .in_is_b(in_is_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_index(out_index), .out_dist(out_dist), .dbg_state(dbg_state)
  );

  color_encoder #(.TRANSPARENT_KEY(12'h000), .KEY_EN(1'b0)) u_dut_nokey (
    .clk(clk), .rst_n(rst_n), .in_valid(nk_in_valid), .in_ready(nk_in_ready),
    .in_rgb(nk_in_rgb), .in_is_b(nk_in_is_b), .out_valid(nk_out_valid),
    .out_ready(nk_out_ready), .out_index(nk_out_index), .out_dist(nk_out_dist),
    .dbg_state(nk_dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one pixel, then follow it to its result with a bounded wait.
  task automatic run_pixel(input logic [11:0] rgb, input logic is_b,
                           input logic [3:0] exp_idx, input logic [9:0] exp_dist,
                           input int exp_lat, input string tag);
    int  lat;
    int  guard;
    bit  ready_seen;
    guard = 0;
    while (!in_ready && guard < 20) begin
      tick();
      guard++;
    end
    check({tag, " in_ready before accept"}, {31'd0, in_ready}, 32'd1);
    in_rgb   = rgb;
    in_is_b  = is_b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_rgb   = 12'($urandom_range(0, 4095));
    in_is_b  = ~is_b;
    lat = 0;
    ready_seen = 1'b0;
    while (!out_valid && lat < 20) begin
      if (in_ready) ready_seen = 1'b1;
      tick();
      lat++;
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " in_ready low while busy"}, {31'd0, ready_seen | in_ready}, 32'd0);
    check({tag, " out_index"}, {28'd0, out_index}, {28'd0, exp_idx});
    check({tag, " out_dist"}, {22'd0, out_dist}, {22'd0, exp_dist});
    if (out_ready) begin
      tick();
      check({tag, " out_valid one cycle"}, {31'd0, out_valid}, 32'd0);
      check({tag, " in_ready after handshake"}, {31'd0, in_ready}, 32'd1);
    end
  endtask

  initial begin
    logic [3:0] held_idx;
    logic [9:0] held_dist;
    int         guard;
    bit         spurious;

    rst_n = 1'b0; in_valid = 1'b0; in_rgb = 12'h000; in_is_b = 1'b0; out_ready = 1'b1;
    nk_in_valid = 1'b0; nk_in_rgb = 12'h000; nk_in_is_b = 1'b0; nk_out_ready = 1'b1;
    tick();
    tick();
    check("reset in_ready low", {31'd0, in_ready}, 32'd0);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset out_index", {28'd0, out_index}, 32'd0);
    check("reset out_dist", {22'd0, out_dist}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("in_ready after release", {31'd0, in_ready}, 32'd1);

    // Exact palette hits and nearest searches.
    run_pixel(12'hFF9, 1'b0, 4'd3, 10'd0, 8, "ff9");
    run_pixel(12'h8DF, 1'b1, 4'd1, 10'd0, 8, "8df_b");
    run_pixel(12'h8DF, 1'b0, 4'd8, 10'd53, 8, "8df_a");
    run_pixel(12'hFFC, 1'b0, 4'd3, 10'd9, 8, "tie_ffc");
    run_pixel(12'h009, 1'b1, 4'd2, 10'd0, 8, "009_b");
    run_pixel(12'h6B4, 1'b1, 4'd6, 10'd0, 8, "6b4");
    run_pixel(12'h000, 1'b0, 4'd0, 10'd0, 0, "key");

    // Same black pixel through the instance with the key disabled.
    nk_in_rgb = 12'h000;
    nk_in_valid = 1'b1;
    tick();
    nk_in_valid = 1'b0;
    guard = 0;
    while (!nk_out_valid && guard < 20) begin
      tick();
      guard++;
    end
    check("nokey latency", guard, 8);
    check("nokey out_index", {28'd0, nk_out_index}, 32'd4);
    check("nokey out_dist", {22'd0, nk_out_dist}, 32'd5);

    // Backpressure: result must hold and new pixels must be refused.
    out_ready = 1'b0;
    run_pixel(12'hDD0, 1'b0, 4'd7, 10'd0, 8, "bp");
    held_idx = out_index;
    held_dist = out_dist;
    spurious = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_rgb = 12'h210;
      tick();
      if (!out_valid || in_ready || out_index !== held_idx || out_dist !== held_dist)
        spurious = 1'b1;
    end
    in_valid = 1'b0;
    check("bp hold stable", {31'd0, spurious}, 32'd0);
    check("bp held index", {28'd0, out_index}, 32'd7);
    out_ready = 1'b1;
    tick();
    check("bp release out_valid", {31'd0, out_valid}, 32'd0);
    check("bp release in_ready", {31'd0, in_ready}, 32'd1);
    in_rgb = 12'h778;
    in_is_b = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("bp next accepted", {30'd0, dbg_state}, 32'd1);
    guard = 0;
    while (!out_valid && guard < 20) begin
      tick();
      guard++;
    end
    check("bp next index", {28'd0, out_index}, 32'd5);
    tick();

    // Reset while scanning entry 4.
    in_rgb = 12'hFF9;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("mid reset in_ready low", {31'd0, in_ready}, 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check("mid reset state idle", {30'd0, dbg_state}, 32'd0);
    check("mid reset in_ready", {31'd0, in_ready}, 32'd1);
    spurious = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) spurious = 1'b1;
      tick();
    end
    check("mid reset no out_valid", {31'd0, spurious}, 32'd0);
    run_pixel(12'hD42, 1'b0, 4'd1, 10'd0, 8, "d42_after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
